jlsemi_util_clkdiv_data_gearbox: RTL and testbench

- Fast-clock-domain write side of the divided-clock read strobe (DATA_RD_EN) produced by the even clock divider.
- Packs narrow per-cycle samples into a wide word. On each read strobe, transfers the word into a holding register that stays stable for a full strobe interval, so the divided-clock domain can capture it safely.
- Also provides a toggle flag, a valid-lane count and sticky error flags for the capture path.

---
 rtl/jlsemi_util_clkdiv_data_gearbox.sv | 126 ++++++++++++
 tb/tb_jlsemi_util_clkdiv_data_gearbox.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jlsemi_util_clkdiv_data_gearbox.sv
// Packs narrow fast-clock samples into a wide word and hands it to the divided-clock
// domain on each read strobe. The output word holds steady between strobes.
module jlsemi_util_clkdiv_data_gearbox #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int CNT_W  = 6
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      enable,
    input  logic                      rd_en,
    input  logic [DATA_W-1:0]         din,
    input  logic                      din_vld,
    input  logic                      err_clr,
    output logic [DATA_W*LANES-1:0]   dout,
    output logic [CNT_W-1:0]          dout_cnt,
    output logic                      dout_tgl,
    output logic                      aligned,
    output logic                      ovf_err,
    output logic                      udf_err
);

    localparam int               WORD_W  = DATA_W * LANES;
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    typedef enum logic {
        WAIT_ALIGN = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [WORD_W-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]    lane_ptr_q, lane_ptr_d;
    logic [WORD_W-1:0]   dout_q,     dout_d;
    logic [CNT_W-1:0]    dout_cnt_q, dout_cnt_d;
    logic                dout_tgl_q, dout_tgl_d;
    logic                aligned_q,  aligned_d;
    logic                ovf_err_q,  ovf_err_d;
    logic                udf_err_q,  udf_err_d;
    logic                ovf_set;
    logic                udf_set;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        lane_ptr_d = lane_ptr_q;
        dout_d     = dout_q;
        dout_cnt_d = dout_cnt_q;
        dout_tgl_d = dout_tgl_q;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;

        if (state_q == WAIT_ALIGN) begin
            // The aligning strobe only marks the word boundary; nothing is transferred.
            acc_d      = '0;
            lane_ptr_d = '0;
            if (enable && rd_en) begin
                state_d = RUN;
            end
        end else if (!enable) begin
            state_d    = WAIT_ALIGN;
            acc_d      = '0;
            lane_ptr_d = '0;
        end else if (rd_en) begin
            dout_d     = acc_q;
            dout_cnt_d = lane_ptr_q;
            dout_tgl_d = ~dout_tgl_q;
            udf_set    = (lane_ptr_q == '0);
            acc_d      = '0;
            lane_ptr_d = '0;
            // A sample coinciding with the strobe opens the next word.
            if (din_vld) begin
                acc_d[DATA_W-1:0] = din;
                lane_ptr_d        = CNT_W'(1);
            end
        end else if (din_vld) begin
            if (lane_ptr_q < LANES_C) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_ptr_q == CNT_W'(k)) begin
                        acc_d[k*DATA_W +: DATA_W] = din;
                    end
                end
                lane_ptr_d = lane_ptr_q + CNT_W'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end

        // Set beats clear when both happen in the same cycle.
        ovf_err_d = ovf_set | (ovf_err_q & ~err_clr);
        udf_err_d = udf_set | (udf_err_q & ~err_clr);
        aligned_d = (state_d == RUN);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= WAIT_ALIGN;
            acc_q      <= '0;
            lane_ptr_q <= '0;
            dout_q     <= '0;
            dout_cnt_q <= '0;
            dout_tgl_q <= 1'b0;
            aligned_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
            udf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            lane_ptr_q <= lane_ptr_d;
            dout_q     <= dout_d;
            dout_cnt_q <= dout_cnt_d;
            dout_tgl_q <= dout_tgl_d;
            aligned_q  <= aligned_d;
            ovf_err_q  <= ovf_err_d;
            udf_err_q  <= udf_err_d;
        end
    end

    assign dout     = dout_q;
    assign dout_cnt = dout_cnt_q;
    assign dout_tgl = dout_tgl_q;
    assign aligned  = aligned_q;
    assign ovf_err  = ovf_err_q;
    assign udf_err  = udf_err_q;

endmodule

// File: tb/tb_jlsemi_util_clkdiv_data_gearbox.sv
// Bench for the clock-divider data gearbox: directed scenarios plus random traffic,
// scored against a sample-queue reference model.
module tb_jlsemi_util_clkdiv_data_gearbox;

    localparam int DATA_W = 8;
    localparam int LANES  = 8;
    localparam int CNT_W  = 6;
    localparam int WORD_W = DATA_W * LANES;

    logic                clk = 1'b0;
    logic                rst_in = 1'b0;
    logic                enable = 1'b0;
    logic                rd_en = 1'b0;
    logic [DATA_W-1:0]   din = '0;
    logic                din_vld = 1'b0;
    logic                err_clr = 1'b0;
    logic [WORD_W-1:0]   dout;
    logic [CNT_W-1:0]    dout_cnt;
    logic                dout_tgl;
    logic                aligned;
    logic                ovf_err;
    logic                udf_err;

    jlsemi_util_clkdiv_data_gearbox #(
        .DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)
    ) dut (
        .clk_in  (clk),
        .rst_in  (rst_in),
        .enable  (enable),
        .rd_en   (rd_en),
        .din     (din),
        .din_vld (din_vld),
        .err_clr (err_clr),
        .dout    (dout),
        .dout_cnt(dout_cnt),
        .dout_tgl(dout_tgl),
        .aligned (aligned),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] word;
        logic [CNT_W-1:0]  cnt;
        int                cyc;
    } xfer_t;

    xfer_t             sb[$];
    logic [DATA_W-1:0] m_words[$];
    logic              m_running = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;
    logic              last_rst = 1'b0;
    logic              mon_en = 1'b0;
    int                cycle = 0;
    int                tests_run = 0;
    int                tests_failed = 0;

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [WORD_W-1:0] pack_words();
        logic [WORD_W-1:0] w = '0;
        for (int k = 0; k < m_words.size(); k++) w[k*DATA_W +: DATA_W] = m_words[k];
        return w;
    endfunction

    // Reference model: one call per clock edge with the inputs sampled on that edge.
    task automatic model_edge(input logic en, input logic rd, input logic dv,
                              input logic [DATA_W-1:0] d, input logic clr, input logic rst);
        logic ovf_s = 1'b0;
        logic udf_s = 1'b0;
        xfer_t x;
        if (rst) begin
            m_running = 1'b0;
            m_words.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        if (!m_running) begin
            if (rd && en) m_running = 1'b1;
        end else if (!en) begin
            m_running = 1'b0;
            m_words.delete();
        end else if (rd) begin
            x.word = pack_words();
            x.cnt  = CNT_W'(m_words.size());
            x.cyc  = cycle;
            sb.push_back(x);
            udf_s = (m_words.size() == 0);
            m_words.delete();
            if (dv) m_words.push_back(d);
        end else if (dv) begin
            if (m_words.size() < LANES) m_words.push_back(d);
            else ovf_s = 1'b1;
        end
        m_ovf = ovf_s | (m_ovf & ~clr);
        m_udf = udf_s | (m_udf & ~clr);
    endtask

    task automatic step(input logic en, input logic rd, input logic dv,
                        input logic [DATA_W-1:0] d, input logic clr, input logic rst);
        enable  = en;
        rd_en   = rd;
        din_vld = dv;
        din     = d;
        err_clr = clr;
        rst_in  = rst;
        @(posedge clk);
        cycle++;
        model_edge(en, rd, dv, d, clr, rst);
        last_rst = rst;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic sample(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"},     dout, '0);
        chk({tag, "_cnt"},      WORD_W'(dout_cnt), '0);
        chk({tag, "_tgl"},      WORD_W'(dout_tgl), '0);
        chk({tag, "_aligned"},  WORD_W'(aligned), '0);
        chk({tag, "_ovf"},      WORD_W'(ovf_err), '0);
        chk({tag, "_udf"},      WORD_W'(udf_err), '0);
    endtask

    // Monitor: pops an expected word whenever the toggle flag changes.
    logic              prev_tgl;
    logic [WORD_W-1:0] prev_dout;
    logic [CNT_W-1:0]  prev_cnt;
    always @(negedge clk) begin
        if (mon_en) begin
            if (last_rst) begin
                prev_tgl  = dout_tgl;
                prev_dout = dout;
                prev_cnt  = dout_cnt;
            end else begin
                if (dout_tgl !== prev_tgl) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_tgl", WORD_W'(dout_tgl), WORD_W'(prev_tgl));
                    end else begin
                        xfer_t e;
                        e = sb.pop_front();
                        chk("sb_dout", dout, e.word);
                        chk("sb_cnt", WORD_W'(dout_cnt), WORD_W'(e.cnt));
                        chk("sb_latency", WORD_W'(cycle), WORD_W'(e.cyc));
                    end
                end else begin
                    chk("hold_dout", dout, prev_dout);
                    chk("hold_cnt", WORD_W'(dout_cnt), WORD_W'(prev_cnt));
                end
                prev_tgl  = dout_tgl;
                prev_dout = dout;
                prev_cnt  = dout_cnt;
            end
            chk("aligned", WORD_W'(aligned), WORD_W'(m_running));
            chk("ovf_err", WORD_W'(ovf_err), WORD_W'(m_ovf));
            chk("udf_err", WORD_W'(udf_err), WORD_W'(m_udf));
        end
    end

    initial begin
        logic [WORD_W-1:0] held;
        logic              held_tgl;
        int                gap;
        logic              r_rd;
        logic              r_rst;

        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_reset_state("reset");

        // Align: samples before the first strobe are discarded, no transfer.
        for (int i = 0; i < 10; i++) sample(8'(8'h11 + i));
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("align_tgl", WORD_W'(dout_tgl), '0);
        chk("align_aligned", WORD_W'(aligned), 1);

        // Full word.
        for (int i = 1; i <= 8; i++) sample(8'(i));
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("full_dout", dout, 64'h0807060504030201);
        chk("full_cnt", WORD_W'(dout_cnt), 8);
        chk("full_tgl", WORD_W'(dout_tgl), 1);
        chk("full_ovf", WORD_W'(ovf_err), 0);

        // Overflow: ten samples into an eight-lane word.
        for (int i = 0; i < 10; i++) sample(8'(8'h31 + i));
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf_dout", dout, 64'h3837363534333231);
        chk("ovf_cnt", WORD_W'(dout_cnt), 8);
        chk("ovf_set", WORD_W'(ovf_err), 1);
        idle(5);
        chk("ovf_sticky", WORD_W'(ovf_err), 1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("ovf_clr", WORD_W'(ovf_err), 0);

        // Collision: strobe with a valid sample.
        sample(8'hA1);
        sample(8'hA2);
        sample(8'hA3);
        step(1'b1, 1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
        chk("coll_dout", dout, 64'h0000000000A3A2A1);
        chk("coll_cnt", WORD_W'(dout_cnt), 3);
        idle(3);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("coll_next_dout", dout, 64'h00000000000000B0);
        chk("coll_next_cnt", WORD_W'(dout_cnt), 1);

        // Underflow and clear.
        idle(4);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("udf_dout", dout, '0);
        chk("udf_cnt", WORD_W'(dout_cnt), 0);
        chk("udf_set", WORD_W'(udf_err), 1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("udf_clr", WORD_W'(udf_err), 0);

        // Mid-word disable: outputs hold, the next strobe only re-aligns.
        for (int i = 0; i < 4; i++) sample(8'(8'hC0 + i));
        held     = dout;
        held_tgl = dout_tgl;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("dis_aligned", WORD_W'(aligned), 0);
        chk("dis_hold", dout, held);
        idle(1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("dis_realign_tgl", WORD_W'(dout_tgl), WORD_W'(held_tgl));
        chk("dis_realign_aligned", WORD_W'(aligned), 1);

        // Mid-word reset.
        idle(4);
        for (int i = 0; i < 4; i++) sample(8'(8'hD0 + i));
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_reset_state("midrst");

        // Random traffic with strobes at least four cycles apart.
        gap = 4;
        for (int n = 0; n < 3000; n++) begin
            r_rd  = (gap >= 4) && ($urandom_range(0, 5) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            gap   = r_rd ? 1 : gap + 1;
            step($urandom_range(0, 59) != 0, r_rd, $urandom_range(0, 9) < 7,
                 8'($urandom), $urandom_range(0, 19) == 0, r_rst);
        end
        idle(3);
        chk("sb_empty", WORD_W'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
